// File: rtl/ram_3d_banked_clr.sv
// ram_3d_banked_clr: multi-bank true-dual-port RAM with clear sweep, selectable read latency and collision flags
module ram_3d_banked_clr #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 1,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_done,
  input  logic [NUM_BANKS-1:0] ena,
  input  logic [NUM_BANKS-1:0] enb,
  input  logic [NUM_BANKS-1:0] wea,
  input  logic [NUM_BANKS-1:0] web,
  input  logic [ADDR_W-1:0]    addra [NUM_BANKS],
  input  logic [ADDR_W-1:0]    addrb [NUM_BANKS],
  input  logic [DATA_W-1:0]    dina [NUM_BANKS],
  input  logic [DATA_W-1:0]    dinb [NUM_BANKS],
  output logic [DATA_W-1:0]    douta [NUM_BANKS],
  output logic [DATA_W-1:0]    doutb [NUM_BANKS],
  output logic [NUM_BANKS-1:0] vala,
  output logic [NUM_BANKS-1:0] valb,
  output logic [NUM_BANKS-1:0] coll
);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic done_nx, idle;
  logic [DATA_W-1:0] mem [NUM_BANKS][2**ADDR_W];
  logic [DATA_W-1:0] qa [NUM_BANKS];
  logic [DATA_W-1:0] qb [NUM_BANKS];
  logic [NUM_BANKS-1:0] qva, qvb, wra, wrb, cl;
  generate
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("RD_LAT must be 1 or 2");
    end
  endgenerate
  assign idle = state == IDLE;
  assign busy = !idle;
  assign wra = ena & wea;
  assign wrb = enb & web;
  // same-address write pair per bank; port A wins
  always_comb begin
    cl = '0;
    for (int i = 0; i < NUM_BANKS; i++) cl[i] = wra[i] && wrb[i] && addra[i] == addrb[i];
  end
  // sweep sequencing: advance pointer while clearing, re-arm on request when idle
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    done_nx = 1'b0;
    if (state == CLEAR) begin
      ptr_nx = ptr + 1'b1;
      state_nx = ptr == '1 ? IDLE : CLEAR;
      done_nx = ptr == '1;
    end else if (clr_req) begin
      state_nx = CLEAR;
      ptr_nx = '0;
    end
  end
  // state register; reset restarts the sweep from the first address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      ptr <= '0;
      clr_done <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      clr_done <= done_nx;
    end
  end
  // array writes: sweep value while clearing, else port writes with A taking priority
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!idle) mem[i][ptr] <= CLR_VAL;
      else begin
        if (wrb[i] && !cl[i]) mem[i][addrb[i]] <= dinb[i];
        if (wra[i]) mem[i][addra[i]] <= dina[i];
      end
    end
  end
  // first read stage (read-first), valid strobes and collision pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        qa[i] <= '0;
        qb[i] <= '0;
      end
      qva <= '0;
      qvb <= '0;
      coll <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (idle && ena[i]) qa[i] <= mem[i][addra[i]];
        if (idle && enb[i]) qb[i] <= mem[i][addrb[i]];
      end
      qva <= idle ? ena : '0;
      qvb <= idle ? enb : '0;
      coll <= idle ? cl : '0;
    end
  end
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] ra [NUM_BANKS];
      logic [DATA_W-1:0] rb [NUM_BANKS];
      logic [NUM_BANKS-1:0] rva, rvb;
      // extra output stage delaying data and valid together
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < NUM_BANKS; i++) begin
            ra[i] <= '0;
            rb[i] <= '0;
          end
          rva <= '0;
          rvb <= '0;
        end else begin
          ra <= qa;
          rb <= qb;
          rva <= qva;
          rvb <= qvb;
        end
      end
      assign douta = ra;
      assign doutb = rb;
      assign vala = rva;
      assign valb = rvb;
    end else begin : g_lat1
      assign douta = qa;
      assign doutb = qb;
      assign vala = qva;
      assign valb = qvb;
    end
  endgenerate
endmodule

// File: tb/tb_ram_3d_banked_clr.sv
// tb_ram_3d_banked_clr: checks latency-1 and latency-2 builds against a behavioural RAM model
module tb_ram_3d_banked_clr;
  localparam int NB = 4, DW = 16, AW = 6, DEPTH = 64;
  logic clk = 0, rst = 1, clr_req = 0;
  logic [NB-1:0] ena = 0, enb = 0, wea = 0, web = 0;
  logic [AW-1:0] addra [NB], addrb [NB];
  logic [DW-1:0] dina [NB], dinb [NB];
  logic busy1, done1, busy2, done2;
  logic [DW-1:0] douta1 [NB], doutb1 [NB], douta2 [NB], doutb2 [NB];
  logic [NB-1:0] vala1, valb1, coll1, vala2, valb2, coll2;
  int total = 0, bad = 0;
  logic [DW-1:0] mm [NB][DEPTH];
  bit mbusy, mdone;
  int cidx;
  logic [DW-1:0] xa [NB], xb [NB], xa2 [NB], xb2 [NB];
  bit [NB-1:0] xva, xvb, xva2, xvb2, xcoll;
  typedef struct {
    int bk;
    bit ea, wa; int aa; logic [DW-1:0] da;
    bit eb, wb; int ab; logic [DW-1:0] db;
    bit xva; logic [DW-1:0] xda;
    bit xvb; logic [DW-1:0] xdb;
    bit xc;
  } vec_t;
  vec_t tv [9];

  always #5 clk = ~clk;

  ram_3d_banked_clr #(.RD_LAT(1)) u1 (.clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1), .clr_done(done1),
    .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta1), .doutb(doutb1), .vala(vala1), .valb(valb1), .coll(coll1));
  ram_3d_banked_clr #(.RD_LAT(2)) u2 (.clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy2), .clr_done(done2),
    .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta2), .doutb(doutb2), .vala(vala2), .valb(valb2), .coll(coll2));

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic idle();
    ena = 0; enb = 0; wea = 0; web = 0; clr_req = 0;
    for (int b = 0; b < NB; b++) begin
      addra[b] = 0; addrb[b] = 0; dina[b] = 0; dinb[b] = 0;
    end
  endtask

  task automatic rnd_ports(int amax);
    ena = 4'($urandom); enb = 4'($urandom); wea = 4'($urandom); web = 4'($urandom);
    for (int b = 0; b < NB; b++) begin
      addra[b] = 6'($urandom_range(0, amax)); addrb[b] = 6'($urandom_range(0, amax));
      dina[b] = 16'($urandom); dinb[b] = 16'($urandom);
    end
  endtask

  // model: what one clock edge does to contents and outputs, from the behavioural rules
  task automatic model_edge();
    if (rst) begin
      mbusy = 1; cidx = 0; mdone = 0; xcoll = 0;
      xva = 0; xvb = 0; xva2 = 0; xvb2 = 0;
      for (int b = 0; b < NB; b++) begin xa[b] = 0; xb[b] = 0; xa2[b] = 0; xb2[b] = 0; end
      return;
    end
    xa2 = xa; xb2 = xb; xva2 = xva; xvb2 = xvb;
    mdone = 0; xcoll = 0; xva = 0; xvb = 0;
    if (mbusy) begin
      for (int b = 0; b < NB; b++) mm[b][cidx] = 16'h0000;
      cidx++;
      if (cidx == DEPTH) begin mbusy = 0; mdone = 1; end
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (ena[b]) begin xa[b] = mm[b][addra[b]]; xva[b] = 1; end
        if (enb[b]) begin xb[b] = mm[b][addrb[b]]; xvb[b] = 1; end
        xcoll[b] = ena[b] && wea[b] && enb[b] && web[b] && addra[b] == addrb[b];
        if (enb[b] && web[b]) mm[b][addrb[b]] = dinb[b];
        if (ena[b] && wea[b]) mm[b][addra[b]] = dina[b];
      end
      if (clr_req) begin mbusy = 1; cidx = 0; end
    end
  endtask

  task automatic cmp_all();
    chk("busy1", 32'(busy1), 32'(mbusy)); chk("busy2", 32'(busy2), 32'(mbusy));
    chk("done1", 32'(done1), 32'(mdone)); chk("done2", 32'(done2), 32'(mdone));
    chk("coll1", 32'(coll1), 32'(xcoll)); chk("coll2", 32'(coll2), 32'(xcoll));
    chk("vala1", 32'(vala1), 32'(xva)); chk("valb1", 32'(valb1), 32'(xvb));
    chk("vala2", 32'(vala2), 32'(xva2)); chk("valb2", 32'(valb2), 32'(xvb2));
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("douta1[%0d]", b), 32'(douta1[b]), 32'(xa[b]));
      chk($sformatf("doutb1[%0d]", b), 32'(doutb1[b]), 32'(xb[b]));
      chk($sformatf("douta2[%0d]", b), 32'(douta2[b]), 32'(xa2[b]));
      chk($sformatf("doutb2[%0d]", b), 32'(doutb2[b]), 32'(xb2[b]));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  // counts edges until the sweep ends and clr_done pulses seen; optionally hammers ports meanwhile
  task automatic sweep_check(string n, bit rnd);
    int edges = 0, dn = 0;
    do begin
      if (rnd) rnd_ports(63); else idle();
      step();
      edges++;
      if (done1) dn++;
    end while (busy1 && edges < 200);
    idle();
    step();
    if (done1) dn++;
    chk({n, "_edges"}, 32'(edges), 32'(DEPTH));
    chk({n, "_pulses"}, 32'(dn), 32'd1);
  endtask

  initial begin
    tv[0] = '{2, 1, 1, 5, 16'hBEEF, 0, 0, 0, 16'h0, 1, 16'h0000, 0, 16'h0, 0};
    tv[1] = '{2, 0, 0, 0, 16'h0, 1, 0, 5, 16'h0, 0, 16'h0, 1, 16'hBEEF, 0};
    tv[2] = '{1, 1, 1, 9, 16'h1111, 1, 0, 9, 16'h0, 1, 16'h0000, 1, 16'h0000, 0};
    tv[3] = '{1, 0, 0, 0, 16'h0, 1, 0, 9, 16'h0, 0, 16'h0, 1, 16'h1111, 0};
    tv[4] = '{0, 1, 1, 12, 16'hAAAA, 1, 1, 12, 16'h5555, 1, 16'h0000, 1, 16'h0000, 1};
    tv[5] = '{0, 1, 0, 12, 16'h0, 1, 0, 12, 16'h0, 1, 16'hAAAA, 1, 16'hAAAA, 0};
    tv[6] = '{0, 1, 1, 20, 16'h0001, 1, 1, 21, 16'h0002, 1, 16'h0000, 1, 16'h0000, 0};
    tv[7] = '{0, 1, 0, 21, 16'h0, 1, 0, 20, 16'h0, 1, 16'h0002, 1, 16'h0001, 0};
    tv[8] = '{3, 1, 0, 5, 16'h0, 0, 0, 0, 16'h0, 1, 16'h0000, 0, 16'h0, 0};
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
    sweep_check("init_sweep", 0);
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      ena = 4'hF; enb = 4'hF;
      for (int b = 0; b < NB; b++) begin addra[b] = 6'(a); addrb[b] = 6'(DEPTH - 1 - a); end
      step();
    end
    idle();
    step();
    step();
    for (int k = 0; k < 9; k++) begin
      idle();
      ena[tv[k].bk] = tv[k].ea; wea[tv[k].bk] = tv[k].wa; addra[tv[k].bk] = 6'(tv[k].aa); dina[tv[k].bk] = tv[k].da;
      enb[tv[k].bk] = tv[k].eb; web[tv[k].bk] = tv[k].wb; addrb[tv[k].bk] = 6'(tv[k].ab); dinb[tv[k].bk] = tv[k].db;
      step();
      chk($sformatf("vec%0d_vala", k), 32'(vala1[tv[k].bk]), 32'(tv[k].xva));
      chk($sformatf("vec%0d_valb", k), 32'(valb1[tv[k].bk]), 32'(tv[k].xvb));
      chk($sformatf("vec%0d_coll", k), 32'(coll1[tv[k].bk]), 32'(tv[k].xc));
      if (tv[k].xva) chk($sformatf("vec%0d_douta", k), 32'(douta1[tv[k].bk]), 32'(tv[k].xda));
      if (tv[k].xvb) chk($sformatf("vec%0d_doutb", k), 32'(doutb1[tv[k].bk]), 32'(tv[k].xdb));
      idle();
      step();
      chk($sformatf("vec%0d_lat2_valb", k), 32'(valb2[tv[k].bk]), 32'(tv[k].xvb));
      if (tv[k].xvb) chk($sformatf("vec%0d_lat2_doutb", k), 32'(doutb2[tv[k].bk]), 32'(tv[k].xdb));
    end
    idle();
    ena[3] = 1; wea[3] = 1; addra[3] = 3; dina[3] = 16'h1234;
    step();
    idle();
    ena[3] = 1; addra[3] = 3;
    step();
    chk("pre_clr_rd", 32'(douta1[3]), 32'h1234);
    idle();
    clr_req = 1;
    step();
    sweep_check("req_sweep", 1);
    idle();
    ena[3] = 1; addra[3] = 3;
    step();
    chk("post_clr_rd", 32'(douta1[3]), 32'h0000);
    idle();
    clr_req = 1;
    step();
    idle();
    clr_req = 1;
    for (int i = 0; i < 20; i++) step();
    rst = 1;
    idle();
    step();
    step();
    rst = 0;
    sweep_check("rst_sweep", 0);
    for (int i = 0; i < 600; i++) begin
      rnd_ports(7);
      clr_req = $urandom_range(0, 150) == 0;
      step();
    end
    idle();
    for (int i = 0; i < 70; i++) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
